// File: rtl/matrix_add_stream.sv
// Handshaked elementwise H x W matrix adder/accumulator, one row per cycle with W adders.
// Optional signed saturation of every result element when MATRIX_ADD_SAT_EN is defined.
module matrix_add_stream #(
    parameter int unsigned bitlength = 8,
    parameter int unsigned H         = 3,
    parameter int unsigned W         = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [1:0]                              mode,
    input  logic [H-1:0][W-1:0][bitlength-1:0]      AI,
    input  logic [H-1:0][W-1:0][bitlength-1:0]      BI,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [H-1:0][W-1:0][bitlength-1:0]      CO,
    output logic                                    busy
);

    localparam int unsigned ROW_W = (H > 1) ? $clog2(H) : 1;
`ifdef MATRIX_ADD_SAT_EN
    localparam int unsigned SUM_W = bitlength + 1;
`else
    localparam int unsigned SUM_W = bitlength;
`endif

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_ACC  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [1:0]                          state_q;
    logic [1:0]                          state_n;
    logic [H-1:0][W-1:0][bitlength-1:0]  a_q;
    logic [H-1:0][W-1:0][bitlength-1:0]  b_q;
    logic [H-1:0][W-1:0][bitlength-1:0]  acc_q;
    logic [H-1:0][W-1:0][bitlength-1:0]  co_q;
    logic [1:0]                          mode_q;
    logic [ROW_W-1:0]                    row_q;
    logic [W-1:0][bitlength-1:0]         row_res_c;
    logic                                in_ready_q;
    logic                                out_valid_q;
    logic                                busy_q;
    logic                                accept_c;
    logic                                last_row_c;

    assign accept_c   = in_valid && in_ready_q;
    assign last_row_c = (row_q == ROW_W'(H - 1));

    // One adder column per matrix column; the active row is selected by row_q
    for (genvar j = 0; j < W; j++) begin : g_col
        logic [bitlength-1:0] a_e;
        logic [bitlength-1:0] b_e;
        logic [bitlength-1:0] acc_e;
        logic [SUM_W-1:0]     sum_c;
        logic [bitlength-1:0] res_c;

        assign a_e   = a_q[row_q][j];
        assign b_e   = b_q[row_q][j];
        assign acc_e = acc_q[row_q][j];

        always_comb begin
            sum_c = SUM_W'($signed(a_e)) + SUM_W'($signed(b_e));
            case (mode_q)
                MODE_ADD:  sum_c = SUM_W'($signed(a_e)) + SUM_W'($signed(b_e));
                MODE_SUB:  sum_c = SUM_W'($signed(a_e)) - SUM_W'($signed(b_e));
                MODE_ACC:  sum_c = SUM_W'($signed(acc_e)) + SUM_W'($signed(a_e));
                MODE_LOAD: sum_c = SUM_W'($signed(a_e));
                default:   sum_c = SUM_W'($signed(a_e)) + SUM_W'($signed(b_e));
            endcase
        end

`ifdef MATRIX_ADD_SAT_EN
        // Overflow when the extra sign bit disagrees with the result sign bit
        always_comb begin
            res_c = sum_c[bitlength-1:0];
            if (sum_c[bitlength] != sum_c[bitlength-1]) begin
                res_c = sum_c[bitlength] ? {1'b1, {(bitlength-1){1'b0}}}
                                         : {1'b0, {(bitlength-1){1'b1}}};
            end
        end
`else
        assign res_c = sum_c;
`endif

        assign row_res_c[j] = res_c;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_n = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (last_row_c) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Registered status flags, operand capture and row-wise result/accumulator writes
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            co_q        <= '0;
            mode_q      <= MODE_ADD;
            row_q       <= '0;
        end else begin
            in_ready_q  <= (state_n == S_IDLE);
            out_valid_q <= (state_n == S_DONE);
            busy_q      <= (state_n != S_IDLE);
            if (state_q == S_IDLE && accept_c) begin
                a_q    <= AI;
                b_q    <= BI;
                mode_q <= mode;
                row_q  <= '0;
            end
            if (state_q == S_COMPUTE) begin
                co_q[row_q] <= row_res_c;
                if (mode_q[1]) begin
                    acc_q[row_q] <= row_res_c;
                end
                row_q <= row_q + ROW_W'(1);
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign CO        = co_q;

endmodule

// File: tb/tb_matrix_add_stream.sv
// Directed self-checking bench for matrix_add_stream (bitlength=8, H=3, W=4).
// Expected overflow values follow MATRIX_ADD_SAT_EN when it is defined.
module tb_matrix_add_stream;

    typedef logic [2:0][3:0][7:0] mat_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] mode;
    mat_t       AI;
    mat_t       BI;
    logic       out_valid;
    logic       out_ready;
    mat_t       CO;
    logic       busy;

    int n_cmp;
    int n_fail;

    matrix_add_stream #(.bitlength(8), .H(3), .W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .AI        (AI),
        .BI        (BI),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .CO        (CO),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mat_t fill(input logic [7:0] v);
        mat_t m;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = v;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, wait (bounded) for the result, capture CO, complete the output handshake
    task automatic run_op(input logic [1:0] m, input mat_t a, input mat_t b, output mat_t res);
        int k;
        mode     = m;
        AI       = a;
        BI       = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_op_timeout: out_valid=%b after %0d cycles, required 1", out_valid, k);
        end
        res       = CO;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (CO !== fill(8'h00)) begin n_fail++; $display("FAIL reset_co: got %h want 0", CO); end
    endtask

    task automatic test_add();
        int lat;
        mode     = 2'b00;
        AI       = fill(8'd5);
        BI       = fill(8'd3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL add_in_ready_drop: got %b want 0", in_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy: got %b want 1", busy); end
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d want 3", lat); end
        n_cmp++; if (CO !== fill(8'd8)) begin n_fail++; $display("FAIL add_result: got %h want %h", CO, fill(8'd8)); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_after: got %b want 0", busy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_out_valid_drop: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_in_ready_back: got %b want 1", in_ready); end
    endtask

    task automatic test_sub_backpressure();
        mat_t a;
        mat_t b;
        mat_t exp_m;
        int   k;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++) begin
                a[i][j]     = 8'(i * 10 + j);
                b[i][j]     = 8'd1;
                exp_m[i][j] = 8'(i * 10 + j - 1);
            end
        mode     = 2'b01;
        AI       = a;
        BI       = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        n_cmp++; if (CO !== exp_m) begin n_fail++; $display("FAIL sub_result: got %h want %h", CO, exp_m); end
        // Consumer stalls; producer keeps poking in_valid with other data
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            mode     = 2'b00;
            AI       = fill(8'h77);
            BI       = fill(8'h11);
            tick();
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid c=%0d: got %b want 1", c, out_valid); end
            n_cmp++; if (CO !== exp_m) begin n_fail++; $display("FAIL bp_co_stable c=%0d: got %h want %h", c, CO, exp_m); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (4) tick();
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_no_phantom: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_acc();
        mat_t r;
        run_op(2'b11, fill(8'd2), fill(8'hAA), r);
        n_cmp++; if (r !== fill(8'd2)) begin n_fail++; $display("FAIL load_result: got %h want %h", r, fill(8'd2)); end
        run_op(2'b10, fill(8'd3), fill(8'h55), r);
        n_cmp++; if (r !== fill(8'd5)) begin n_fail++; $display("FAIL acc1_result: got %h want %h", r, fill(8'd5)); end
        run_op(2'b00, fill(8'd1), fill(8'd1), r);
        n_cmp++; if (r !== fill(8'd2)) begin n_fail++; $display("FAIL add_between: got %h want %h", r, fill(8'd2)); end
        run_op(2'b10, fill(8'd3), fill(8'h55), r);
        n_cmp++; if (r !== fill(8'd8)) begin n_fail++; $display("FAIL acc2_result: got %h want %h", r, fill(8'd8)); end
        run_op(2'b10, fill(8'd0), fill(8'h33), r);
        n_cmp++; if (r !== fill(8'd8)) begin n_fail++; $display("FAIL acc_zero_result: got %h want %h", r, fill(8'd8)); end
    endtask

    task automatic test_overflow();
        mat_t r;
        logic [7:0] e_add;
        logic [7:0] e_sub;
`ifdef MATRIX_ADD_SAT_EN
        e_add = 8'h7F;
        e_sub = 8'h80;
`else
        e_add = 8'hC8;
        e_sub = 8'h38;
`endif
        run_op(2'b00, fill(8'd100), fill(8'd100), r);
        n_cmp++; if (r !== fill(e_add)) begin n_fail++; $display("FAIL ovf_add: got %h want %h", r, fill(e_add)); end
        run_op(2'b01, fill(8'h9C), fill(8'd100), r);
        n_cmp++; if (r !== fill(e_sub)) begin n_fail++; $display("FAIL ovf_sub: got %h want %h", r, fill(e_sub)); end
    endtask

    task automatic test_reset_mid();
        mat_t r;
        mode     = 2'b10;
        AI       = fill(8'd4);
        BI       = fill(8'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_cmp++; if (CO !== fill(8'd0)) begin n_fail++; $display("FAIL rmid_co: got %h want 0", CO); end
        repeat (4) tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_result: got %b want 0", out_valid); end
        run_op(2'b10, fill(8'd4), fill(8'd9), r);
        n_cmp++; if (r !== fill(8'd4)) begin n_fail++; $display("FAIL rmid_acc_cleared: got %h want %h", r, fill(8'd4)); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] expq[$];
        int         acc_cyc[$];
        int         n_res;
        logic [7:0] v;
        v         = 8'd10;
        n_res     = 0;
        mode      = 2'b00;
        BI        = fill(8'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL b2b_extra_result c=%0d: got %h want none", c, CO);
                end else begin
                    n_cmp++;
                    if (CO !== fill(expq[0])) begin
                        n_fail++; $display("FAIL b2b_result c=%0d: got %h want %h", c, CO, fill(expq[0]));
                    end
                    void'(expq.pop_front());
                end
                n_res++;
            end
            in_valid = (c < 26);
            if (in_valid && in_ready) begin
                AI = fill(v);
                expq.push_back(v + 8'd1);
                acc_cyc.push_back(c);
                v = v + 8'd10;
            end else begin
                AI = fill(8'hEE);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_cmp++;
            if (acc_cyc[i] - acc_cyc[i-1] !== 5) begin
                n_fail++; $display("FAIL b2b_interval i=%0d: got %0d want 5", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        n_cmp++; if (acc_cyc.size() !== 6) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 6", acc_cyc.size()); end
        n_cmp++; if (n_res !== acc_cyc.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", n_res, acc_cyc.size()); end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 2'b00;
        AI        = '0;
        BI        = '0;
        test_reset();
        test_add();
        test_sub_backpressure();
        test_acc();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
